// File: rtl/fl_read_arbiter.sv
// Parallel flash read arbiter: runs the flash power-up reset, then serves two
// word-read clients round-robin with a high-byte-then-low-byte read per grant.
module fl_read_arbiter #(
  parameter int unsigned WAIT_CYCLES = 6,
  parameter int unsigned RST_CYCLES  = 25,
  parameter int unsigned REC_CYCLES  = 3
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        req0,
  input  logic [21:0] addr0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic [21:0] addr1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic [22:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic        init_done,
  output logic        busy
);

  localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] RstLast  = 8'(RST_CYCLES - 1);
  localparam logic [7:0] RecLast  = 8'(REC_CYCLES - 1);

  typedef enum logic [2:0] {
    StResetHold,
    StRecover,
    StIdle,
    StReadHi,
    StReadLo,
    StRespond
  } state_e;

  state_e      state;
  logic [7:0]  cnt;
  logic        last_gnt;
  logic        gnt_id;
  logic [21:0] gnt_addr;
  logic [7:0]  hi;

  logic        req_any;
  logic        pick;
  logic [21:0] pick_addr;

  // The block never writes the flash.
  assign FL_WE_N = 1'b1;

  // Round-robin pick: on contention grant the client that was not served last.
  always_comb begin
    req_any   = req0 | req1;
    pick      = (req0 & req1) ? ~last_gnt : req1;
    pick_addr = pick ? addr1 : addr0;
  end

  // Sequencer: reset hold, recovery, then grant / two byte reads / respond.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= StResetHold;
      cnt       <= 8'd0;
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      gnt_addr  <= 22'd0;
      hi        <= 8'd0;
      FL_ADDR   <= 23'd0;
      FL_CE_N   <= 1'b1;
      FL_OE_N   <= 1'b1;
      FL_RST_N  <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= 16'd0;
      rdata1    <= 16'd0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      cnt     <= cnt + 8'd1;
      unique case (state)
        StResetHold: begin
          if (cnt == RstLast) begin
            state    <= StRecover;
            cnt      <= 8'd0;
            FL_RST_N <= 1'b1;
          end
        end
        StRecover: begin
          if (cnt == RecLast) begin
            state     <= StIdle;
            cnt       <= 8'd0;
            init_done <= 1'b1;
          end
        end
        StIdle: begin
          cnt <= 8'd0;
          if (req_any) begin
            state    <= StReadHi;
            gnt_id   <= pick;
            gnt_addr <= pick_addr;
            last_gnt <= pick;
            FL_ADDR  <= {pick_addr, 1'b0};
            FL_CE_N  <= 1'b0;
            FL_OE_N  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StReadHi: begin
          if (cnt == WaitLast) begin
            state   <= StReadLo;
            cnt     <= 8'd0;
            hi      <= FL_DQ;
            FL_ADDR <= {gnt_addr, 1'b1};
          end
        end
        StReadLo: begin
          if (cnt == WaitLast) begin
            state   <= StRespond;
            cnt     <= 8'd0;
            FL_CE_N <= 1'b1;
            FL_OE_N <= 1'b1;
            // Low byte goes straight into the response word.
            if (gnt_id) begin
              rdata1  <= {hi, FL_DQ};
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= {hi, FL_DQ};
              rvalid0 <= 1'b1;
            end
          end
        end
        StRespond: begin
          state <= StIdle;
          cnt   <= 8'd0;
          busy  <= 1'b0;
        end
        default: begin
          state <= StResetHold;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fl_read_arbiter.sv
// Self-checking bench for fl_read_arbiter: cycle-exact startup check, a table of
// single reads, hand-written reset/alternation/streaming sequences and random rounds.
module tb_fl_read_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [21:0] addr0 = 22'd0;
  logic [21:0] addr1 = 22'd0;
  logic        rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [22:0] FL_ADDR;
  logic [7:0]  FL_DQ;
  logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, init_done, busy;

  fl_read_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .addr1    (addr1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .FL_ADDR  (FL_ADDR),
    .FL_DQ    (FL_DQ),
    .FL_CE_N  (FL_CE_N),
    .FL_OE_N  (FL_OE_N),
    .FL_WE_N  (FL_WE_N),
    .FL_RST_N (FL_RST_N),
    .init_done(init_done),
    .busy     (busy)
  );

  // Flash model: byte at address A reads as A[7:0] while output-enabled.
  assign FL_DQ = FL_OE_N ? 8'hA5 : FL_ADDR[7:0];

  always #5 CLOCK_50 = ~CLOCK_50;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: round-robin pointer and each client's last delivered word.
  logic        m_last;
  logic [15:0] m_rd0, m_rd1;

  typedef struct {
    logic        client;
    logic [21:0] addr;
    logic [15:0] exp_data;
  } rd_vec_t;

  rd_vec_t tbl [6];

  // Word at word-address a: bytes at 2a and 2a+1.
  function automatic logic [15:0] word_of(input logic [21:0] a);
    logic [22:0] b;
    b = {a, 1'b0};
    return {b[7:0], 8'(b[7:0] + 8'd1)};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {1'b0, FL_RST_N, init_done, FL_CE_N, FL_OE_N, FL_WE_N, busy, rvalid0, rvalid1,
            FL_ADDR, rdata0, rdata1};
  endfunction

  function automatic logic [63:0] exp_vec(input logic rstn, input logic init, input logic ce_n,
                                          input logic bsy, input logic rv0, input logic rv1,
                                          input logic [22:0] a, input logic [15:0] d0,
                                          input logic [15:0] d1);
    return {1'b0, rstn, init, ce_n, ce_n, 1'b1, bsy, rv0, rv1, a, d0, d1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for any response pulse; n counts negedges waited.
  task automatic wait_resp(input int budget, output logic [1:0] mask, output int n);
    mask = 2'b00;
    n    = 0;
    while (mask == 2'b00 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      mask = {rvalid1, rvalid0};
    end
  endtask

  // Expect one response from client (exp_mask), with given data and latency.
  task automatic serve(input string name, input logic [1:0] exp_mask, input logic [15:0] data,
                       input int exp_lat, input int budget, input logic drop);
    logic [1:0] mask;
    int         n;
    wait_resp(budget, mask, n);
    check({name, " who"}, 64'(mask), 64'(exp_mask));
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    if (exp_mask[0]) begin
      m_rd0  = data;
      m_last = 1'b0;
    end else begin
      m_rd1  = data;
      m_last = 1'b1;
    end
    check({name, " rdata"}, {32'd0, rdata0, rdata1}, {32'd0, m_rd0, m_rd1});
    if (drop) begin
      if (exp_mask[0]) req0 = 1'b0;
      if (exp_mask[1]) req1 = 1'b0;
    end
  endtask

  // Two-cycle reset; reference model returns to its reset view.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge CLOCK_50);
    check("reset values", obs_vec(), exp_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'd0,
                                              16'd0, 16'd0));
    @(negedge CLOCK_50);
    rst    = 1'b0;
    m_last = 1'b1;
    m_rd0  = 16'd0;
    m_rd1  = 16'd0;
  endtask

  initial begin
    logic [63:0] ev;
    logic        c;
    logic [1:0]  pending;
    logic [21:0] a0, a1;
    int          lat;

    tbl[0] = '{1'b1, 22'h007FFF, 16'hFEFF};
    tbl[1] = '{1'b0, 22'h000010, 16'h2021};
    tbl[2] = '{1'b1, 22'h000020, 16'h4041};
    tbl[3] = '{1'b0, 22'h3FFFFF, 16'hFEFF};
    tbl[4] = '{1'b1, 22'h000000, 16'h0001};
    tbl[5] = '{1'b0, 22'h000080, 16'h0001};

    // Startup with req0 held from time 0: reset hold, recovery, then first read.
    req0  = 1'b1;
    addr0 = 22'h000123;
    do_reset();
    for (int k = 1; k <= 41; k++) begin
      @(negedge CLOCK_50);
      ev = exp_vec(k >= 25, k >= 28, !(k >= 29 && k <= 40), k >= 29, k == 41, 1'b0,
                   (k < 29) ? 23'h0 : ((k <= 34) ? 23'h246 : 23'h247),
                   (k == 41) ? 16'h4647 : 16'h0, 16'h0);
      check($sformatf("startup cycle %0d", k), obs_vec(), ev);
    end
    req0   = 1'b0;
    m_rd0  = 16'h4647;
    m_last = 1'b0;
    @(negedge CLOCK_50);
    check("rvalid0 one cycle", 64'(rvalid0), 64'd0);

    // Table of isolated single reads from an idle arbiter.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].client) begin
        req1  = 1'b1;
        addr1 = tbl[i].addr;
      end else begin
        req0  = 1'b1;
        addr0 = tbl[i].addr;
      end
      serve($sformatf("table %0d", i), tbl[i].client ? 2'b10 : 2'b01, tbl[i].exp_data,
            13, 30, 1'b1);
      @(negedge CLOCK_50);
    end

    // Lone client 1 held high: served every 14 cycles.
    req1  = 1'b1;
    addr1 = 22'h007FFF;
    serve("stream 0", 2'b10, 16'hFEFF, 13, 30, 1'b0);
    serve("stream 1", 2'b10, 16'hFEFF, 14, 30, 1'b0);
    serve("stream 2", 2'b10, 16'hFEFF, 14, 30, 1'b1);
    @(negedge CLOCK_50);

    // Reset in the middle of READ_LO: aborted read never responds.
    req0  = 1'b1;
    addr0 = 22'h000055;
    repeat (9) @(negedge CLOCK_50);
    check("mid-read no rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    do_reset();
    serve("after abort", 2'b01, 16'hAAAB, 41, 60, 1'b1);
    @(negedge CLOCK_50);

    // Both clients pending at first IDLE after reset: 0, 1, 0 alternation.
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 22'h000010;
    addr1 = 22'h000020;
    do_reset();
    serve("alt 0", 2'b01, 16'h2021, 41, 60, 1'b0);
    serve("alt 1", 2'b10, 16'h4041, 14, 30, 1'b0);
    serve("alt 2", 2'b01, 16'h2021, 14, 30, 1'b1);
    req1 = 1'b0;
    @(negedge CLOCK_50);

    // Random rounds against the round-robin reference.
    for (int r = 0; r < 24; r++) begin
      pending = 2'($urandom_range(1, 3));
      a0      = 22'($urandom);
      a1      = 22'($urandom);
      addr0   = a0;
      addr1   = a1;
      req0    = pending[0];
      req1    = pending[1];
      lat     = 13;
      while (pending != 2'b00) begin
        c = (pending == 2'b11) ? ~m_last : pending[1];
        serve($sformatf("rand %0d", r), c ? 2'b10 : 2'b01, word_of(c ? a1 : a0), lat, 30,
              1'b1);
        pending[c] = 1'b0;
        lat        = 14;
      end
      @(negedge CLOCK_50);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
